regfile_write_arbiter: RTL and testbench

//  Owns the single register-file write port (WE3/A3/WD3) and shares it between two writeback requesters:
//  src0 = ALU writeback, src1 = load (LSU) writeback.

---
 rtl/regfile_write_arbiter_if.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Purpose: bundles the writeback request/handshake signals and the
// register-file write port seen by regfile_write_arbiter.
//   master : requesters and register-file side (drive valids/addr/data/clear_req)
//   slave  : the arbiter (drives readies, WE3/A3/WD3, grant_id, busy)
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
);
  logic                     clear_req;
  logic                     src0_valid;
  logic [ADDRESS_WIDTH-1:0] src0_addr;
  logic [DATA_WIDTH-1:0]    src0_data;
  logic                     src0_ready;
  logic                     src1_valid;
  logic [ADDRESS_WIDTH-1:0] src1_addr;
  logic [DATA_WIDTH-1:0]    src1_data;
  logic                     src1_ready;
  logic                     WE3;
  logic [ADDRESS_WIDTH-1:0] A3;
  logic [DATA_WIDTH-1:0]    WD3;
  logic                     grant_id;
  logic                     busy;

  modport master (
    output clear_req,
    output src0_valid, src0_addr, src0_data,
    input  src0_ready,
    output src1_valid, src1_addr, src1_data,
    input  src1_ready,
    input  WE3, A3, WD3, grant_id, busy
  );

  modport slave (
    input  clear_req,
    input  src0_valid, src0_addr, src0_data,
    output src0_ready,
    input  src1_valid, src1_addr, src1_data,
    output src1_ready,
    output WE3, A3, WD3, grant_id, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: owns the single register-file write port and shares it between
// ALU writeback (src0) and LSU writeback (src1) with round-robin arbitration.
// After reset or a clear_req pulse it zeroes every register before accepting
// any writeback.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : slave side of regfile_write_arbiter_if
//          (requests/readies, registered WE3/A3/WD3/grant_id, busy)
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state_q, state_n;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_n;
  logic            last_grant_q, last_grant_n;
  logic            we_q, we_n;
  logic [AW-1:0]   a3_q, a3_n;
  logic [DW-1:0]   wd3_q, wd3_n;
  logic            grant_id_q, grant_id_n;

  logic            run_c;
  logic            grant_c;
  logic            ready0_c;
  logic            ready1_c;
  logic            xfer_c;
  logic [AW-1:0]   xfer_addr_c;
  logic [DW-1:0]   xfer_data_c;

  // Arbitration: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    run_c = (state_q == RUN);
    if (bus.src0_valid && bus.src1_valid) begin
      grant_c = ~last_grant_q;
    end else begin
      grant_c = bus.src1_valid;
    end
    ready0_c    = run_c && bus.src0_valid && !grant_c;
    ready1_c    = run_c && bus.src1_valid &&  grant_c;
    xfer_c      = ready0_c || ready1_c;
    xfer_addr_c = grant_c ? bus.src1_addr : bus.src0_addr;
    xfer_data_c = grant_c ? bus.src1_data : bus.src0_data;
  end

  // Next-state and registered write-port values.
  always_comb begin
    state_n      = state_q;
    clr_cnt_n    = clr_cnt_q;
    last_grant_n = last_grant_q;
    we_n         = 1'b0;
    a3_n         = a3_q;
    wd3_n        = wd3_q;
    grant_id_n   = grant_id_q;

    unique case (state_q)
      CLEAR: begin
        we_n       = 1'b1;
        a3_n       = clr_cnt_q;
        wd3_n      = '0;
        grant_id_n = 1'b0;
        if (clr_cnt_q == LAST_ADDR) begin
          state_n   = RUN;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt_q + AW'(1);
        end
      end
      RUN: begin
        if (xfer_c) begin
          // Writes to x0 are accepted but never reach the register file.
          we_n         = (xfer_addr_c != '0);
          a3_n         = xfer_addr_c;
          wd3_n        = xfer_data_c;
          grant_id_n   = grant_c;
          last_grant_n = grant_c;
        end
        // A same-cycle transfer still lands next cycle; the clear follows it.
        if (bus.clear_req) begin
          state_n   = CLEAR;
          clr_cnt_n = '0;
        end
      end
      default: begin
        state_n = CLEAR;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      a3_q         <= '0;
      wd3_q        <= '0;
      grant_id_q   <= 1'b0;
    end else begin
      state_q      <= state_n;
      clr_cnt_q    <= clr_cnt_n;
      last_grant_q <= last_grant_n;
      we_q         <= we_n;
      a3_q         <= a3_n;
      wd3_q        <= wd3_n;
      grant_id_q   <= grant_id_n;
    end
  end

  assign bus.src0_ready = ready0_c;
  assign bus.src1_ready = ready1_c;
  assign bus.WE3        = we_q;
  assign bus.A3         = a3_q;
  assign bus.WD3        = wd3_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset clear, contention,
// x0 filter, single source, clear_req mid-stream, reset mid-clear.
module tb_regfile_write_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear_req  = 1'b0;
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
  endtask

  // Follow a full clear sequence; optionally pulse clear_req mid-clear (must be ignored).
  task automatic expect_clear(input string tag, input bit poke_clear);
    for (int i = 0; i < 32; i++) begin
      tick();
      bus.clear_req = 1'b0;
      check({tag, "_we"},  64'(bus.WE3),      64'(1));
      check({tag, "_a3"},  64'(bus.A3),       64'(i));
      check({tag, "_wd"},  64'(bus.WD3),      64'(0));
      check({tag, "_gid"}, 64'(bus.grant_id), 64'(0));
      check({tag, "_busy"}, 64'(bus.busy),    (i < 31) ? 64'(1) : 64'(0));
      if (poke_clear && i == 5) bus.clear_req = 1'b1;
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    bus.clear_req  = 1'b0;
    bus.src0_valid = 1'b1;
    bus.src0_addr  = 5'd3;
    bus.src0_data  = 32'h1111_1111;
    bus.src1_valid = 1'b1;
    bus.src1_addr  = 5'd4;
    bus.src1_data  = 32'h2222_2222;

    // Reset: 3 cycles with requesters already valid.
    repeat (3) tick();
    check("rst_we",   64'(bus.WE3),        64'(0));
    check("rst_a3",   64'(bus.A3),         64'(0));
    check("rst_gid",  64'(bus.grant_id),   64'(0));
    check("rst_busy", 64'(bus.busy),       64'(1));
    check("rst_r0",   64'(bus.src0_ready), 64'(0));
    check("rst_r1",   64'(bus.src1_ready), 64'(0));
    rst = 1'b0;

    // Post-reset clear: 32 writes, readies held off despite valid requests.
    for (int i = 0; i < 32; i++) begin
      tick();
      check("clr0_we", 64'(bus.WE3), 64'(1));
      check("clr0_a3", 64'(bus.A3),  64'(i));
      check("clr0_wd", 64'(bus.WD3), 64'(0));
      if (i < 31) begin
        check("clr0_busy", 64'(bus.busy),       64'(1));
        check("clr0_r0",   64'(bus.src0_ready), 64'(0));
        check("clr0_r1",   64'(bus.src1_ready), 64'(0));
      end else begin
        check("clr0_done", 64'(bus.busy), 64'(0));
      end
      if (i == 30) idle_inputs();
    end
    tick();
    check("idle_we", 64'(bus.WE3), 64'(0));

    // Contention: first grant to src0, then strict alternation.
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd1; bus.src0_data = 32'h0000_00A0;
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd2; bus.src1_data = 32'h0000_00B1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_r0", 64'(bus.src0_ready), (k % 2 == 0) ? 64'(1) : 64'(0));
      check("cont_r1", 64'(bus.src1_ready), (k % 2 == 0) ? 64'(0) : 64'(1));
      tick();
      check("cont_we",  64'(bus.WE3),      64'(1));
      check("cont_a3",  64'(bus.A3),       (k % 2 == 0) ? 64'(1) : 64'(2));
      check("cont_wd",  64'(bus.WD3),      (k % 2 == 0) ? 64'(32'hA0) : 64'(32'hB1));
      check("cont_gid", 64'(bus.grant_id), (k % 2 == 0) ? 64'(0) : 64'(1));
    end
    idle_inputs();
    tick();
    check("cont_idle_we", 64'(bus.WE3), 64'(0));

    // x0 filter: accepted but no write; last_grant still moves to src1.
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd0; bus.src1_data = 32'h0000_1234;
    #1;
    check("x0_r1", 64'(bus.src1_ready), 64'(1));
    check("x0_r0", 64'(bus.src0_ready), 64'(0));
    tick();
    check("x0_we", 64'(bus.WE3), 64'(0));
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd1; bus.src0_data = 32'h0000_0C0C;
    bus.src1_addr  = 5'd2;
    #1;
    check("x0_next_r0", 64'(bus.src0_ready), 64'(1));
    check("x0_next_r1", 64'(bus.src1_ready), 64'(0));
    tick();
    check("x0_next_we",  64'(bus.WE3),      64'(1));
    check("x0_next_a3",  64'(bus.A3),       64'(1));
    check("x0_next_gid", 64'(bus.grant_id), 64'(0));
    idle_inputs();

    // Single source.
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd5; bus.src0_data = 32'hDEAD_BEEF;
    #1;
    check("single_r0", 64'(bus.src0_ready), 64'(1));
    tick();
    check("single_we",  64'(bus.WE3),      64'(1));
    check("single_a3",  64'(bus.A3),       64'(5));
    check("single_wd",  64'(bus.WD3),      64'(32'hDEAD_BEEF));
    check("single_gid", 64'(bus.grant_id), 64'(0));
    idle_inputs();
    tick();
    check("single_idle_we", 64'(bus.WE3), 64'(0));
    check("single_hold_a3", 64'(bus.A3),  64'(5));

    // clear_req together with a transfer: write lands, then full clear.
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd7; bus.src0_data = 32'h0000_0077;
    bus.clear_req  = 1'b1;
    #1;
    check("creq_r0", 64'(bus.src0_ready), 64'(1));
    tick();
    bus.clear_req = 1'b0;
    check("creq_we",   64'(bus.WE3),        64'(1));
    check("creq_a3",   64'(bus.A3),         64'(7));
    check("creq_wd",   64'(bus.WD3),        64'(32'h77));
    check("creq_busy", 64'(bus.busy),       64'(1));
    check("creq_r0b",  64'(bus.src0_ready), 64'(0));
    idle_inputs();
    expect_clear("creq_clr", 1'b1);
    tick();
    check("creq_end_we",   64'(bus.WE3),  64'(0));
    check("creq_end_busy", 64'(bus.busy), 64'(0));

    // Reset at clear cycle 10 restarts the sequence from 0.
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    check("rc_busy", 64'(bus.busy), 64'(1));
    check("rc_we",   64'(bus.WE3),  64'(0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rc_a3", 64'(bus.A3), 64'(i));
    end
    rst = 1'b1;
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd9; bus.src1_data = 32'hFFFF_FFFF;
    repeat (2) begin
      tick();
      check("rc_rst_we",   64'(bus.WE3),        64'(0));
      check("rc_rst_a3",   64'(bus.A3),         64'(0));
      check("rc_rst_wd",   64'(bus.WD3),        64'(0));
      check("rc_rst_busy", 64'(bus.busy),       64'(1));
      check("rc_rst_r1",   64'(bus.src1_ready), 64'(0));
    end
    rst = 1'b0;
    idle_inputs();
    expect_clear("rc_clr", 1'b0);
    tick();
    check("rc_end_we", 64'(bus.WE3), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
